toy_fpu_issue_arb: RTL and testbench

Issue-side scheduler for the shared, non-pipelined floating-point execution unit. It arbitrates round-robin among `NUM_REQ` FP issue ports, holds the winning `forward_pkg` stable until the FPU wrapper accepts it, and blocks further issue until the completion pulse returns. It tags each completion with its source port, supports flush of the in-flight op, and guards against a hung unit with a watchdog. It sits between the FP issue queues and `toy_float_wrapper`.

---
 rtl/toy_pack.sv | 20 ++
 rtl/toy_rr_arbiter.sv | 46 ++++
 rtl/toy_fpu_issue_arb.sv | 174 +++++++++++++++++
 tb/tb_toy_fpu_issue_arb.sv | 586 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_pack.sv
// toy_pack: shared FP-side types and constants.
//   forward_pkg     op payload travelling from the issue queues to the FPU
//   FP_STAGES       latency class of the shared FP execution unit
//   FP_ISSUE_PORTS  default number of FP issue ports feeding the arbiter
//   FP_WD_CYCLES    default watchdog limit for an op held inside the FPU
package toy_pack;

  localparam int FP_STAGES      = 5;
  localparam int FP_ISSUE_PORTS = 2;
  localparam int FP_WD_CYCLES   = 16;

  typedef struct packed {
    logic [3:0]  fp_op;
    logic [2:0]  rnd_mode;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [5:0]  rd_tag;
  } forward_pkg;

endpackage

// File: rtl/toy_rr_arbiter.sv
// toy_rr_arbiter: combinational round-robin arbiter.
//   req      in   N      request vector
//   rr_ptr   in   log2N  port where the search starts (highest priority)
//   gnt      out  N      one-hot grant, all zero when no request
//   gnt_idx  out  log2N  encoded grant index, zero when no request
module toy_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  // rot_idx[k] is the port searched k-th, i.e. (rr_ptr + k) mod N.
  logic [IW-1:0] rot_idx [N];
  logic [N-1:0]  rot_req;
  logic          found;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [IW:0] sum;
      assign sum          = {1'b0, rr_ptr} + (IW+1)'(gi);
      assign rot_idx[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      assign rot_req[gi]  = req[rot_idx[gi]];
    end
  endgenerate

  // First requester in rotated order wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot_req[i]) begin
        found            = 1'b1;
        gnt[rot_idx[i]]  = 1'b1;
        gnt_idx          = rot_idx[i];
      end
    end
  end

endmodule

// File: rtl/toy_fpu_issue_arb.sv
// toy_fpu_issue_arb: issue scheduler for the shared non-pipelined FPU.
// Picks one FP issue port round-robin, presents its op to the FPU wrapper
// until accepted, then blocks further issue until the completion pulse.
//   clk, rst              clock, synchronous active-high reset
//   req_vld/req_rdy/req_pld  per-port op handshake (req_rdy is combinational)
//   flush                 kill the op that has not yet completed
//   fpu_vld/fpu_rdy/fpu_pld  op handshake towards the FPU wrapper
//   fpu_done              one-cycle completion pulse from the FPU
//   cpl_vld/cpl_src/cpl_killed  registered completion report to issue side
//   busy                  not idle
//   err                   bit0 watchdog timeout, bit1 stray fpu_done (pulses)
module toy_fpu_issue_arb
  import toy_pack::*;
#(
  parameter int NUM_REQ   = FP_ISSUE_PORTS,
  parameter int WD_CYCLES = FP_WD_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_vld,
  output logic [NUM_REQ-1:0]         req_rdy,
  input  forward_pkg [NUM_REQ-1:0]   req_pld,
  input  logic                       flush,
  output logic                       fpu_vld,
  input  logic                       fpu_rdy,
  output forward_pkg                 fpu_pld,
  input  logic                       fpu_done,
  output logic                       cpl_vld,
  output logic [$clog2(NUM_REQ)-1:0] cpl_src,
  output logic                       cpl_killed,
  output logic                       busy,
  output logic [1:0]                 err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(WD_CYCLES + 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(WD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] src_q, src_d;
  forward_pkg    pld_q, pld_d;
  logic          kill_q, kill_d;
  logic [WW-1:0] wd_q, wd_d, wd_inc;
  logic          cpl_vld_q, cpl_vld_d;
  logic [IW-1:0] cpl_src_q, cpl_src_d;
  logic          cpl_killed_q, cpl_killed_d;
  logic [1:0]    err_q, err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;

  toy_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req_vld),
    .rr_ptr (rr_ptr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  // Saturating watchdog increment.
  assign wd_inc = (wd_q == WD_LIMIT) ? wd_q : wd_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    src_d        = src_q;
    pld_d        = pld_q;
    kill_d       = kill_q;
    wd_d         = wd_q;
    cpl_vld_d    = 1'b0;
    cpl_src_d    = cpl_src_q;
    cpl_killed_d = cpl_killed_q;
    err_d        = 2'b00;
    req_rdy      = '0;

    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          req_rdy = gnt;
        end
        if (fpu_done) begin
          err_d[1] = 1'b1;
        end
        // gnt is only non-zero for a valid port, so any rdy bit is a handshake.
        if (|req_rdy) begin
          pld_d    = req_pld[gnt_idx];
          src_d    = gnt_idx;
          rr_ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (fpu_done) begin
          err_d[1] = 1'b1;
        end
        if (fpu_rdy) begin
          // Once accepted the FPU will finish the op, so a flush here only
          // marks the result as dead.
          state_d = ST_BUSY;
          wd_d    = '0;
          kill_d  = flush;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        wd_d = wd_inc;
        if (fpu_done) begin
          cpl_vld_d    = 1'b1;
          cpl_src_d    = src_q;
          cpl_killed_d = kill_q | flush;
          kill_d       = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          if (flush) begin
            kill_d = 1'b1;
          end
          if (wd_inc == WD_LIMIT) begin
            err_d[0] = 1'b1;
            kill_d   = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      src_q        <= '0;
      pld_q        <= '0;
      kill_q       <= 1'b0;
      wd_q         <= '0;
      cpl_vld_q    <= 1'b0;
      cpl_src_q    <= '0;
      cpl_killed_q <= 1'b0;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      src_q        <= src_d;
      pld_q        <= pld_d;
      kill_q       <= kill_d;
      wd_q         <= wd_d;
      cpl_vld_q    <= cpl_vld_d;
      cpl_src_q    <= cpl_src_d;
      cpl_killed_q <= cpl_killed_d;
      err_q        <= err_d;
    end
  end

  assign fpu_vld    = (state_q == ST_ISSUE);
  assign fpu_pld    = pld_q;
  assign busy       = (state_q != ST_IDLE);
  assign cpl_vld    = cpl_vld_q;
  assign cpl_src    = cpl_src_q;
  assign cpl_killed = cpl_killed_q;
  assign err        = err_q;

endmodule

// File: tb/tb_toy_fpu_issue_arb.sv
module tb_toy_fpu_issue_arb;
  import toy_pack::*;

  localparam int N  = 2;
  localparam int WD = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_vld;
  logic [N-1:0]         req_rdy;
  forward_pkg [N-1:0]   req_pld;
  logic                 flush;
  logic                 fpu_vld;
  logic                 fpu_rdy;
  forward_pkg           fpu_pld;
  logic                 fpu_done;
  logic                 cpl_vld;
  logic [$clog2(N)-1:0] cpl_src;
  logic                 cpl_killed;
  logic                 busy;
  logic [1:0]           err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_at = -1;
  bit auto_en = 1'b0;
  int lat = 5;

  always #5 clk = ~clk;

  toy_fpu_issue_arb #(.NUM_REQ(N), .WD_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_pld(req_pld),
    .flush(flush), .fpu_vld(fpu_vld), .fpu_rdy(fpu_rdy), .fpu_pld(fpu_pld),
    .fpu_done(fpu_done), .cpl_vld(cpl_vld), .cpl_src(cpl_src), .cpl_killed(cpl_killed),
    .busy(busy), .err(err)
  );

  function automatic forward_pkg rand_pld();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[$bits(forward_pkg)-1:0];
  endfunction

  // Round-robin rule: first valid port scanning upward from p, wrapping.
  function automatic int winner(int p, logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    req_vld = '0;
    flush   = 1'b0;
    fpu_rdy = 1'b0;
    for (int i = 0; i < N; i++) req_pld[i] = rand_pld();
  endtask

  // A cycle: inputs driven after the falling edge, outputs sampled 1ns later.
  task automatic start_cycle();
    @(negedge clk);
    cyc++;
    fpu_done = auto_en && (cyc == done_at);
  endtask

  // Behavioural FPU: completes a fixed latency after its accept cycle.
  task automatic end_cycle();
    if (auto_en && fpu_vld && fpu_rdy) done_at = cyc + lat;
  endtask

  task automatic do_reset();
    auto_en  = 1'b0;
    done_at  = -1;
    rst      = 1'b1;
    fpu_done = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({req_rdy, fpu_vld, fpu_pld, cpl_vld, cpl_src, cpl_killed, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b pld=%h cpl=%b src=%0d kill=%b busy=%b err=%b expected all zero",
               req_rdy, fpu_vld, fpu_pld, cpl_vld, cpl_src, cpl_killed, busy, err);
    end
    req_vld = 2'b10;
    #1;
    checks++;
    if (req_rdy !== 2'b10) begin
      errors++;
      $display("FAIL reset_rdy_single: got %b expected 10", req_rdy);
    end
    req_vld = 2'b11;
    #1;
    checks++;
    if (req_rdy !== 2'b01) begin
      errors++;
      $display("FAIL reset_rdy_ptr0: got %b expected 01", req_rdy);
    end
    req_vld = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] grdy[$];
    int           gcyc[$];
    int           csrc[$];
    logic [N-1:0] e;
    do_reset();
    auto_en = 1'b1;
    lat     = 5;
    for (int k = 0; k < 32; k++) begin
      start_cycle();
      req_vld = 2'b11;
      fpu_rdy = 1'b1;
      for (int i = 0; i < N; i++) req_pld[i] = rand_pld();
      #1;
      if (req_rdy != '0) begin
        grdy.push_back(req_rdy);
        gcyc.push_back(cyc);
      end
      if (cpl_vld) begin
        csrc.push_back(int'(cpl_src));
        $display("rr: completion src=%0d killed=%0b cycle=%0d", cpl_src, cpl_killed, cyc);
      end
      end_cycle();
    end
    checks++;
    if (grdy.size() < 4 || csrc.size() < 4) begin
      errors++;
      $display("FAIL rr_counts: got grants=%0d cpls=%0d expected >=4 each", grdy.size(), csrc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = '0;
        e[i % 2] = 1'b1;
        checks++;
        if (grdy[i] !== e) begin
          errors++;
          $display("FAIL rr_grant%0d: got %b expected %b", i, grdy[i], e);
        end
        checks++;
        if (csrc[i] != i % 2) begin
          errors++;
          $display("FAIL rr_cpl_src%0d: got %0d expected %0d", i, csrc[i], i % 2);
        end
        if (i > 0) begin
          checks++;
          if (gcyc[i] - gcyc[i-1] != 7) begin
            errors++;
            $display("FAIL rr_gap%0d: got %0d expected 7", i, gcyc[i] - gcyc[i-1]);
          end
        end
      end
    end
    auto_en = 1'b0;
  endtask

  task automatic test_rdy_stall();
    forward_pkg p;
    int acc;
    bit got;
    do_reset();
    auto_en = 1'b1;
    lat     = 3;
    start_cycle();
    p = rand_pld();
    req_vld = 2'b01;
    req_pld[0] = p;
    #1;
    checks++;
    if (req_rdy !== 2'b01) begin
      errors++;
      $display("FAIL stall_grant: got %b expected 01", req_rdy);
    end
    end_cycle();
    for (int k = 0; k < 4; k++) begin
      start_cycle();
      req_vld = 2'b01;
      req_pld[0] = rand_pld();
      fpu_rdy = (k == 3);
      #1;
      checks++;
      if (fpu_vld !== 1'b1 || fpu_pld !== p) begin
        errors++;
        $display("FAIL stall_hold%0d: got vld=%b pld=%h expected vld=1 pld=%h", k, fpu_vld, fpu_pld, p);
      end
      acc = cyc;
      end_cycle();
    end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      start_cycle();
      req_vld = '0;
      fpu_rdy = 1'b0;
      #1;
      if (k == 0) begin
        checks++;
        if (busy !== 1'b1 || fpu_vld !== 1'b0) begin
          errors++;
          $display("FAIL stall_busy: got busy=%b vld=%b expected busy=1 vld=0", busy, fpu_vld);
        end
      end
      if (cpl_vld) begin
        got = 1'b1;
        checks++;
        if (cyc != acc + 4 || cpl_src !== 1'b0 || cpl_killed !== 1'b0) begin
          errors++;
          $display("FAIL stall_cpl: got cycle=%0d src=%0d killed=%b expected cycle=%0d src=0 killed=0",
                   cyc, cpl_src, cpl_killed, acc + 4);
        end
      end
      end_cycle();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL stall_cpl_timeout: got no cpl_vld expected one");
    end
    auto_en = 1'b0;
  endtask

  task automatic test_flush();
    int ncpl;
    bit got;
    do_reset();
    // flush blocks grant in idle
    start_cycle();
    req_vld = 2'b11;
    flush = 1'b1;
    #1;
    checks++;
    if (req_rdy !== 2'b00) begin
      errors++;
      $display("FAIL flush_idle_rdy: got %b expected 00", req_rdy);
    end
    // flush in ISSUE without fpu_rdy drops the op
    start_cycle();
    flush = 1'b0;
    req_vld = 2'b10;
    #1;
    checks++;
    if (busy !== 1'b0 || req_rdy !== 2'b10) begin
      errors++;
      $display("FAIL flush_grant1: got busy=%b rdy=%b expected busy=0 rdy=10", busy, req_rdy);
    end
    start_cycle();
    req_vld = '0;
    flush = 1'b1;
    fpu_rdy = 1'b0;
    #1;
    ncpl = 0;
    for (int k = 0; k < 8; k++) begin
      start_cycle();
      flush = 1'b0;
      #1;
      if (k == 0) begin
        checks++;
        if (busy !== 1'b0 || fpu_vld !== 1'b0) begin
          errors++;
          $display("FAIL flush_issue_drop: got busy=%b vld=%b expected 0 0", busy, fpu_vld);
        end
      end
      if (cpl_vld) ncpl++;
    end
    checks++;
    if (ncpl != 0) begin
      errors++;
      $display("FAIL flush_issue_nocpl: got %0d completions expected 0", ncpl);
    end
    // flush together with fpu_rdy: accepted, completes killed
    auto_en = 1'b1;
    lat = 4;
    start_cycle();
    req_vld = 2'b01;
    #1;
    checks++;
    if (req_rdy !== 2'b01) begin
      errors++;
      $display("FAIL flush_grant0: got %b expected 01", req_rdy);
    end
    end_cycle();
    start_cycle();
    req_vld = '0;
    flush = 1'b1;
    fpu_rdy = 1'b1;
    #1;
    end_cycle();
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      start_cycle();
      flush = 1'b0;
      fpu_rdy = 1'b0;
      #1;
      if (cpl_vld) begin
        got = 1'b1;
        checks++;
        if (cpl_killed !== 1'b1 || cpl_src !== 1'b0) begin
          errors++;
          $display("FAIL flush_accept_cpl: got killed=%b src=%0d expected killed=1 src=0", cpl_killed, cpl_src);
        end
      end
      end_cycle();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL flush_accept_timeout: got no cpl_vld expected one");
    end
    auto_en = 1'b0;
  endtask

  task automatic test_flush_busy();
    do_reset();
    start_cycle();
    req_vld = 2'b10;
    #1;
    start_cycle();
    req_vld = '0;
    fpu_rdy = 1'b1;
    #1;
    start_cycle();
    fpu_rdy = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || fpu_vld !== 1'b0) begin
      errors++;
      $display("FAIL fbusy_state: got busy=%b vld=%b expected busy=1 vld=0", busy, fpu_vld);
    end
    start_cycle();
    flush = 1'b1;
    #1;
    start_cycle();
    flush = 1'b0;
    #1;
    start_cycle();
    fpu_done = 1'b1;
    #1;
    checks++;
    if (cpl_vld !== 1'b0) begin
      errors++;
      $display("FAIL fbusy_early_cpl: got %b expected 0", cpl_vld);
    end
    // completion cycle; a new grant is already possible here
    start_cycle();
    req_vld = 2'b11;
    #1;
    checks++;
    if (cpl_vld !== 1'b1 || cpl_killed !== 1'b1 || cpl_src !== 1'b1 || req_rdy !== 2'b01) begin
      errors++;
      $display("FAIL fbusy_cpl: got cpl=%b killed=%b src=%0d rdy=%b expected 1 1 1 01",
               cpl_vld, cpl_killed, cpl_src, req_rdy);
    end
    start_cycle();
    req_vld = '0;
    fpu_rdy = 1'b1;
    #1;
    start_cycle();
    fpu_rdy = 1'b0;
    fpu_done = 1'b1;
    #1;
    start_cycle();
    #1;
    checks++;
    if (cpl_vld !== 1'b1 || cpl_killed !== 1'b0 || cpl_src !== 1'b0) begin
      errors++;
      $display("FAIL fbusy_next_cpl: got cpl=%b killed=%b src=%0d expected 1 0 0", cpl_vld, cpl_killed, cpl_src);
    end
  endtask

  task automatic test_watchdog();
    int a;
    logic [1:0] exp_err;
    logic exp_busy;
    do_reset();
    start_cycle();
    req_vld = 2'b01;
    #1;
    start_cycle();
    req_vld = '0;
    fpu_rdy = 1'b1;
    #1;
    a = cyc;
    for (int k = 0; k < 20; k++) begin
      start_cycle();
      fpu_rdy = 1'b0;
      #1;
      exp_err  = (cyc == a + 17) ? 2'b01 : 2'b00;
      exp_busy = (cyc < a + 17);
      checks++;
      if (err !== exp_err || busy !== exp_busy || cpl_vld !== 1'b0) begin
        errors++;
        $display("FAIL watchdog_c%0d: got err=%b busy=%b cpl=%b expected err=%b busy=%b cpl=0",
                 cyc - a, err, busy, cpl_vld, exp_err, exp_busy);
      end
    end
  endtask

  task automatic test_stray_done();
    do_reset();
    start_cycle();
    fpu_done = 1'b1;
    #1;
    start_cycle();
    #1;
    checks++;
    if (err !== 2'b10) begin
      errors++;
      $display("FAIL stray_idle_err: got %b expected 10", err);
    end
    start_cycle();
    req_vld = 2'b10;
    #1;
    checks++;
    if (err !== 2'b00 || req_rdy !== 2'b10) begin
      errors++;
      $display("FAIL stray_idle_pulse: got err=%b rdy=%b expected err=00 rdy=10", err, req_rdy);
    end
    start_cycle();
    req_vld = '0;
    fpu_done = 1'b1;
    #1;
    start_cycle();
    #1;
    checks++;
    if (err !== 2'b10 || fpu_vld !== 1'b1) begin
      errors++;
      $display("FAIL stray_issue_err: got err=%b vld=%b expected err=10 vld=1", err, fpu_vld);
    end
    start_cycle();
    flush = 1'b1;
    #1;
    start_cycle();
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_issue_drop: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_cycle();
    req_vld = 2'b01;
    #1;
    start_cycle();
    req_vld = '0;
    fpu_rdy = 1'b1;
    #1;
    start_cycle();
    fpu_rdy = 1'b0;
    #1;
    start_cycle();
    rst = 1'b1;
    #1;
    start_cycle();
    rst = 1'b0;
    fpu_done = 1'b1;
    #1;
    checks++;
    if ({req_rdy, fpu_vld, fpu_pld, cpl_vld, cpl_src, cpl_killed, busy, err} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got vld=%b pld=%h cpl=%b busy=%b err=%b expected all zero",
               fpu_vld, fpu_pld, cpl_vld, busy, err);
    end
    start_cycle();
    req_vld = 2'b11;
    #1;
    checks++;
    if (err !== 2'b10 || req_rdy !== 2'b01) begin
      errors++;
      $display("FAIL midreset_late_done: got err=%b rdy=%b expected err=10 rdy=01", err, req_rdy);
    end
    start_cycle();
    req_vld = '0;
    flush = 1'b1;
    #1;
    start_cycle();
    flush = 1'b0;
    #1;
  endtask

  task automatic test_random();
    int ptr, w, msrc, cpl_src_p, done_m;
    bit holding, in_unit, mkill, cpl_p, cpl_kill_p, idle;
    logic [1:0] err_p;
    logic [N-1:0] exp_rdy;
    forward_pkg mpld;
    do_reset();
    ptr = 0; holding = 0; in_unit = 0; mkill = 0; cpl_p = 0; cpl_kill_p = 0;
    cpl_src_p = 0; msrc = 0; err_p = 2'b00; done_m = -1; mpld = '0;
    for (int k = 0; k < 800; k++) begin
      start_cycle();
      req_vld = N'($urandom());
      for (int i = 0; i < N; i++) req_pld[i] = rand_pld();
      flush   = ($urandom_range(0, 15) == 0);
      fpu_rdy = ($urandom_range(0, 2) != 0);
      fpu_done = (cyc == done_m) || (!in_unit && $urandom_range(0, 31) == 0);
      #1;
      idle = !holding && !in_unit;
      w = winner(ptr, req_vld);
      exp_rdy = '0;
      if (idle && !flush && w >= 0) exp_rdy[w] = 1'b1;
      checks++;
      if (req_rdy !== exp_rdy) begin
        errors++;
        $display("FAIL rand_rdy c%0d: got %b expected %b", cyc, req_rdy, exp_rdy);
      end
      checks++;
      if (fpu_vld !== holding || busy !== !idle || (holding && fpu_pld !== mpld)) begin
        errors++;
        $display("FAIL rand_fpu c%0d: got vld=%b busy=%b pld=%h expected vld=%b busy=%b pld=%h",
                 cyc, fpu_vld, busy, fpu_pld, holding, !idle, mpld);
      end
      checks++;
      if (cpl_vld !== cpl_p || err !== err_p ||
          (cpl_p && (int'(cpl_src) != cpl_src_p || cpl_killed !== cpl_kill_p))) begin
        errors++;
        $display("FAIL rand_cpl c%0d: got cpl=%b src=%0d kill=%b err=%b expected cpl=%b src=%0d kill=%b err=%b",
                 cyc, cpl_vld, cpl_src, cpl_killed, err, cpl_p, cpl_src_p, cpl_kill_p, err_p);
      end
      if (cpl_p) $display("rand: completion src=%0d killed=%0b cycle=%0d", cpl_src_p, cpl_kill_p, cyc);
      cpl_p = 1'b0;
      err_p = 2'b00;
      if (idle) begin
        if (fpu_done) err_p[1] = 1'b1;
        if (exp_rdy != '0) begin
          holding = 1'b1;
          mpld = req_pld[w];
          msrc = w;
          ptr = (w + 1) % N;
        end
      end else if (holding) begin
        if (fpu_done) err_p[1] = 1'b1;
        if (fpu_rdy) begin
          holding = 1'b0;
          in_unit = 1'b1;
          mkill = flush;
          done_m = cyc + $urandom_range(1, 8);
        end else if (flush) begin
          holding = 1'b0;
        end
      end else begin
        if (fpu_done) begin
          cpl_p = 1'b1;
          cpl_src_p = msrc;
          cpl_kill_p = mkill || flush;
          in_unit = 1'b0;
          mkill = 1'b0;
        end else if (flush) begin
          mkill = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    fpu_done = 1'b0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_rdy_stall();
    test_flush();
    test_flush_busy();
    test_watchdog();
    test_stray_done();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
